// File: rtl/unified_buffer_mc.sv
// unified_buffer_mc: NUM_CH independent FIFOs sharing one {ch, ptr} storage array, drained through one registered output stage.
// Define UB_OVF_ERR_EN to build sticky per-channel overflow flags on err_ovf; otherwise err_ovf is tied to 0.
module unified_buffer_mc #(
  parameter  int WIDTH    = 8,
  parameter  int DEPTH    = 256,
  parameter  int NUM_CH   = 4,
  parameter  int AF_LEVEL = DEPTH - 4,
  localparam int CH_W     = $clog2(NUM_CH),
  localparam int ADDR_W   = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              wr_valid,
  input  logic [CH_W-1:0]   wr_ch,
  input  logic [WIDTH-1:0]  wr_data,
  output logic              wr_ready,
  input  logic [CH_W-1:0]   rd_ch,
  output logic              rd_valid,
  output logic [WIDTH-1:0]  rd_data,
  output logic [CH_W-1:0]   rd_ch_out,
  input  logic              rd_ready,
  input  logic              flush_valid,
  input  logic [CH_W-1:0]   flush_ch,
  output logic [NUM_CH-1:0] full,
  output logic [NUM_CH-1:0] empty,
  output logic [NUM_CH-1:0] almost_full,
  output logic [ADDR_W:0]   count_sel,
  output logic [NUM_CH-1:0] err_ovf
);

  localparam int              CNT_W    = ADDR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_CNT   = CNT_W'(AF_LEVEL);

  logic [WIDTH-1:0]                r_mem [NUM_CH*DEPTH];
  logic [NUM_CH-1:0][ADDR_W-1:0]   w_wr_ptr;
  logic [NUM_CH-1:0][ADDR_W-1:0]   w_rd_ptr;
  logic [NUM_CH-1:0][CNT_W-1:0]    w_count;
  logic [NUM_CH-1:0]               w_full;
  logic [NUM_CH-1:0]               w_empty;
  logic                            w_wr_flush_hit;
  logic                            w_rd_flush_hit;
  logic                            w_wr_fire;
  logic                            w_load;
  logic                            r_rd_valid;
  logic [WIDTH-1:0]                r_rd_data;
  logic [CH_W-1:0]                 r_rd_ch_out;

  assign w_wr_flush_hit = flush_valid & (flush_ch == wr_ch);
  assign w_rd_flush_hit = flush_valid & (flush_ch == rd_ch);
  assign wr_ready       = ~w_full[wr_ch] & ~w_wr_flush_hit;
  assign w_wr_fire      = wr_valid & wr_ready;
  assign w_load         = (~r_rd_valid | rd_ready) & ~w_empty[rd_ch] & ~w_rd_flush_hit;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    localparam logic [CH_W-1:0] CH = CH_W'(g);
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              w_inc;
    logic              w_dec;
    logic              w_flush;

    assign w_inc   = w_wr_fire & (wr_ch == CH);
    assign w_dec   = w_load & (rd_ch == CH);
    assign w_flush = flush_valid & (flush_ch == CH);

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
      end else if (w_flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_inc) r_wr_ptr <= r_wr_ptr + 1'b1;
        if (w_dec) r_rd_ptr <= r_rd_ptr + 1'b1;
        if (w_inc & ~w_dec)      r_count <= r_count + 1'b1;
        else if (~w_inc & w_dec) r_count <= r_count - 1'b1;
      end
    end

    assign w_wr_ptr[g]    = r_wr_ptr;
    assign w_rd_ptr[g]    = r_rd_ptr;
    assign w_count[g]     = r_count;
    assign w_full[g]      = (r_count == FULL_CNT);
    assign w_empty[g]     = (r_count == '0);
    assign almost_full[g] = (r_count >= AF_CNT);
  end

  // Storage is deliberately not reset; occupancy is tracked solely by the per-channel counters.
  always_ff @(posedge clk) begin
    if (w_wr_fire) r_mem[{wr_ch, w_wr_ptr[wr_ch]}] <= wr_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rd_valid  <= 1'b0;
      r_rd_data   <= '0;
      r_rd_ch_out <= '0;
    end else if (w_load) begin
      r_rd_valid  <= 1'b1;
      r_rd_data   <= r_mem[{rd_ch, w_rd_ptr[rd_ch]}];
      r_rd_ch_out <= rd_ch;
    end else if (flush_valid && (flush_ch == r_rd_ch_out)) begin
      r_rd_valid  <= 1'b0;
    end else if (r_rd_valid && rd_ready) begin
      r_rd_valid  <= 1'b0;
    end
  end

  assign rd_valid  = r_rd_valid;
  assign rd_data   = r_rd_data;
  assign rd_ch_out = r_rd_ch_out;
  assign full      = w_full;
  assign empty     = w_empty;
  assign count_sel = w_count[rd_ch];

`ifdef UB_OVF_ERR_EN
  logic [NUM_CH-1:0] r_err_ovf;
  logic [NUM_CH-1:0] w_ovf_set;
  logic [NUM_CH-1:0] w_ovf_clr;

  assign w_ovf_set = {NUM_CH{wr_valid}} & w_full & (NUM_CH'(1) << wr_ch);
  assign w_ovf_clr = {NUM_CH{flush_valid}} & (NUM_CH'(1) << flush_ch);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_err_ovf <= '0;
    else          r_err_ovf <= (r_err_ovf | w_ovf_set) & ~w_ovf_clr;
  end

  assign err_ovf = r_err_ovf;
`else
  assign err_ovf = '0;
`endif

endmodule
